flash_read_arbiter: RTL and testbench
=====================================

# flash_read_arbiter

Shares the single serial-flash byte reader between two requesters: port 0 (instruction fetch) and port 1 (data/constant load). Each request is 1–4 consecutive bytes. The block sequences the reader's enable/address handshake once per byte and assembles the result into a little-endian 32-bit word. It sits between the CPU fetch/load units and the flash reader, and is the only block that drives the reader's `enable` and `addr`.

## Interface
- `RELEASE_CYCLES`, default 2: cycles `flash_enable` is held low after each byte, so the reader returns to idle (minimum 2).
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0` / `req1` input 1: request level. Held high with `addrN`/`lenN` stable until `ackN`.
- `addr0` / `addr1` input 24: flash byte address of the first byte.
- `len0` / `len1` input 2: byte count minus 1 (0 = 1 byte … 3 = 4 bytes).
- `ack0` / `ack1` output 1: one-cycle pulse; `rdata` is valid in that cycle.
- `rdata` output 32: assembled word. Byte k goes to [8k+7:8k]; unrequested bytes are 0. Holds its value until the next ack.
- `busy` output 1: high in every state except IDLE.
- `flash_enable` output 1: drives the reader's enable.
- `flash_addr` output 24: drives the reader's addr.
- `flash_byte` input 8: reader's byte output.
- `flash_ready` input 1: reader's data-ready. Stays high after a byte until the next enable is accepted.

## Operation
- Reset values: `ack0`, `ack1`, `busy` and `flash_enable` = 0; `flash_addr` = 0; `rdata` = 0; state = IDLE; `last_grant` = 1, so port 0 wins the first tie.

States:
- **IDLE**
  - Only one `req` high: grant it.
  - Both high: grant the port that is not `last_grant`.
  - On grant: latch `addr`/`len`, clear the byte index and the assembly register to 0, set `last_grant`, go to ISSUE.
- **ISSUE**
  - `flash_enable` = 1, `flash_addr` = latched address.
  - Wait until `flash_ready` = 0. This rejects the stale ready left over from the previous byte. Then go to WAIT.
- **WAIT**
  - `flash_enable` = 1.
  - When `flash_ready` = 1: write `flash_byte` into byte lane [index], increment the address (24-bit, 0xFFFFFF wraps to 0x000000), increment the index, go to RELEASE.
- **RELEASE**
  - `flash_enable` = 0 for exactly `RELEASE_CYCLES` cycles.
  - Then: if index ≤ latched `len`, go to ISSUE; otherwise go to DONE.
- **DONE**
  - Copy the assembly register to `rdata`.
  - Pulse the granted `ackN` for one cycle.
  - Go to IDLE.

Rules:
- A grant is locked for the whole burst. A request arriving mid-burst waits; it is never dropped.
- `addr`/`len` changes after grant are ignored.
- `req` dropped mid-burst: the burst still completes and `ack` still pulses. The requester must tolerate this.
- `ack0` and `ack1` are never high together.
- Reset mid-burst: all outputs return to reset values immediately and the burst is lost. With `flash_enable` low, the reader finishes its current byte and idles.

## Timing
- Grant: the cycle after `req` is seen high in IDLE, the state is ISSUE and `flash_enable` is high.
- Per byte: (ISSUE cycles until ready low) + (WAIT cycles until ready high) + `RELEASE_CYCLES`.
- `ack` comes 1 cycle after the last RELEASE. The next arbitration happens in the following IDLE cycle, so there is a minimum 1-cycle IDLE gap between bursts.
- Back-to-back requests from the same port, with `req` held high: a new grant occurs if the other port is idle. Otherwise the other port wins (round-robin).
- `flash_addr` only changes while `flash_enable` = 0, or on the grant cycle.

## Test plan
- **Single-byte fetch.** Model byte = addr[7:0] ^ 0xA5. Request `req0`, `addr0`=0x000100, `len0`=0 → exactly 1 enable/ready handshake, then `ack0` with `rdata`=0x000000A5.
- **4-byte load.** `req1`, `addr1`=0x000010, `len1`=3 → 4 handshakes at addresses 0x10–0x13; `rdata`=0xB6B7B4B5; `flash_enable` low for 2 cycles between bytes.
- **Contention.** `req0` and `req1` rise in the same cycle, both held → port 0 served first. A second `req0` arriving during port 1's burst waits; the order is port 0, port 1, port 0.
- **Address wrap.** `addr0`=0xFFFFFE, `len0`=3 → bytes fetched from 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; `rdata`=0xA4A55A5B.
- **Stale-ready rejection.** Model holds `flash_ready`=1 after a byte until the enable is re-accepted → no byte is captured before ready falls, and each lane holds the correct byte.
- **Reset mid-burst.** `rst_n` low during the 3rd byte of a 4-byte burst → outputs go to 0 immediately and no `ack`. After release, a new `req0` completes normally.

Source files
------------

// File: rtl/flash_read_arbiter_if.sv
// Signal bundle between the fetch/load requesters, the arbiter and the serial-flash byte reader.
// The master modport is the requester/reader side; the slave modport is the arbiter.
interface flash_read_arbiter_if;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 2;
  localparam int unsigned BYTE_W = 8;

  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [LEN_W-1:0]  len0;
  logic [LEN_W-1:0]  len1;
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              flash_enable;
  logic [ADDR_W-1:0] flash_addr;
  logic [BYTE_W-1:0] flash_byte;
  logic              flash_ready;

  modport master (
    output req0, req1, addr0, addr1, len0, len1, flash_byte, flash_ready,
    input  ack0, ack1, rdata, busy, flash_enable, flash_addr
  );

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, flash_byte, flash_ready,
    output ack0, ack1, rdata, busy, flash_enable, flash_addr
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one serial-flash byte reader between fetch (port 0) and load (port 1),
// assembling 1-4 byte bursts into a little-endian word.
module flash_read_arbiter #(
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  flash_read_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 2;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = $clog2(RELEASE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RELEASE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                port_q, port_d;
  logic                last_grant_q, last_grant_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                enable_q, enable_d;
  logic                busy_q, busy_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                grant1_c;

  // Port 1 wins when it is alone, or on a tie when port 0 was served last.
  assign grant1_c = bus.req1 && (!bus.req0 || !last_grant_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      port_q       <= 1'b0;
      last_grant_q <= 1'b1;
      len_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      asm_q        <= '0;
      addr_q       <= '0;
      rdata_q      <= '0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    len_d        = len_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          port_d       = grant1_c;
          last_grant_d = grant1_c;
          len_d        = grant1_c ? bus.len1 : bus.len0;
          addr_d       = grant1_c ? bus.addr1 : bus.addr0;
          idx_d        = '0;
          asm_d        = '0;
          state_d      = S_ISSUE;
        end
      end
      // Ready still high here is left over from the previous byte; wait for the reader to drop it.
      S_ISSUE: begin
        if (!bus.flash_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.flash_ready) begin
          asm_d[{idx_q[1:0], 3'b000} +: 8] = bus.flash_byte;
          addr_d  = addr_q + ADDR_W'(1);
          idx_d   = idx_q + IDX_W'(1);
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (cnt_q == CNT_LAST) begin
          if (idx_q <= {1'b0, len_q}) begin
            state_d = S_ISSUE;
          end else begin
            rdata_d = asm_q;
            ack0_d  = !port_q;
            ack1_d  = port_q;
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    enable_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    busy_d   = (state_d != S_IDLE);
  end

  assign bus.ack0         = ack0_q;
  assign bus.ack1         = ack1_q;
  assign bus.rdata        = rdata_q;
  assign bus.busy         = busy_q;
  assign bus.flash_enable = enable_q;
  assign bus.flash_addr   = addr_q;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// Scoreboard bench for flash_read_arbiter: a reader model returns addr[7:0]^0xA5 and
// holds ready high until the next enable; expected acks and byte addresses are queued.
module tb_flash_read_arbiter;
  logic clk;
  logic rst_n;

  flash_read_arbiter_if bus_if ();

  flash_read_arbiter #(.RELEASE_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int tests;
  int fails;

  logic        exp_port[$];
  logic [31:0] exp_data[$];
  logic [23:0] exp_addr[$];

  // Reader model state
  int          m_st;
  int          m_cnt;
  int          lat;
  int          accept_cnt;
  logic [23:0] m_addr;

  // Enable/address protocol checker state
  int          low_cnt;
  logic        prev_en;
  logic [23:0] prev_faddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Serial-flash reader model
  always @(posedge clk) begin
    case (m_st)
      0: if (bus_if.flash_enable) begin
           tests++;
           if (exp_addr.size() == 0) begin
             fails++;
             $display("FAIL handshake_addr: unexpected enable at 0x%06h", bus_if.flash_addr);
           end else begin
             logic [23:0] ea;
             ea = exp_addr.pop_front();
             if (bus_if.flash_addr !== ea) begin
               fails++;
               $display("FAIL handshake_addr: got 0x%06h expected 0x%06h", bus_if.flash_addr, ea);
             end
           end
           bus_if.flash_ready <= 1'b0;
           m_addr     <= bus_if.flash_addr;
           m_cnt      <= lat;
           m_st       <= 1;
           accept_cnt <= accept_cnt + 1;
         end
      1: if (m_cnt == 0) begin
           bus_if.flash_byte  <= m_addr[7:0] ^ 8'hA5;
           bus_if.flash_ready <= 1'b1;
           m_st <= 2;
         end else begin
           m_cnt <= m_cnt - 1;
         end
      default: if (!bus_if.flash_enable) m_st <= 0;
    endcase
  end

  // Output monitor: ack scoreboard, ack exclusivity, release gap and address stability
  always @(negedge clk) begin
    if (bus_if.ack0 && bus_if.ack1) begin
      tests++;
      fails++;
      $display("FAIL ack_exclusive: ack0=1 ack1=1 required at most one");
    end
    if (bus_if.ack0 || bus_if.ack1) begin
      tests++;
      if (exp_port.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: ack0=%0b ack1=%0b rdata=0x%08h", bus_if.ack0, bus_if.ack1, bus_if.rdata);
      end else begin
        logic        ep;
        logic [31:0] ed;
        ep = exp_port.pop_front();
        ed = exp_data.pop_front();
        if (bus_if.ack1 !== ep || bus_if.rdata !== ed) begin
          fails++;
          $display("FAIL ack_data: port %0b rdata 0x%08h expected port %0b rdata 0x%08h",
                   bus_if.ack1, bus_if.rdata, ep, ed);
        end
      end
    end
    if (!bus_if.busy) begin
      low_cnt = 0;
    end else if (bus_if.flash_enable) begin
      if (low_cnt != 0) chk("release_gap", 32'(low_cnt), 32'd2);
      low_cnt = 0;
      if (prev_en && bus_if.flash_addr !== prev_faddr)
        chk("addr_stable", 32'(bus_if.flash_addr), 32'(prev_faddr));
    end else begin
      low_cnt++;
    end
    prev_en    = bus_if.flash_enable;
    prev_faddr = bus_if.flash_addr;
  end

  task automatic run_port(input int p, input logic [23:0] a, input logic [1:0] l);
    int n;
    if (p == 0) begin
      bus_if.addr0 = a; bus_if.len0 = l; bus_if.req0 = 1'b1;
    end else begin
      bus_if.addr1 = a; bus_if.len1 = l; bus_if.req1 = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(p == 0 ? bus_if.ack0 : bus_if.ack1) && n < 2000);
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL ack_timeout: port %0d no ack after %0d cycles", p, n);
    end
    if (p == 0) bus_if.req0 = 1'b0;
    else        bus_if.req1 = 1'b0;
  endtask

  task automatic push_burst(input logic port, input logic [23:0] a, input int nbytes, input logic [31:0] d);
    for (int i = 0; i < nbytes; i++) exp_addr.push_back(a + 24'(i));
    exp_port.push_back(port);
    exp_data.push_back(d);
  endtask

  initial begin
    int n;
    tests = 0; fails = 0;
    m_st = 0; m_cnt = 0; lat = 1; accept_cnt = 0; m_addr = '0;
    low_cnt = 0; prev_en = 1'b0; prev_faddr = '0;
    bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
    bus_if.addr0 = '0; bus_if.addr1 = '0;
    bus_if.len0 = '0; bus_if.len1 = '0;
    bus_if.flash_byte = '0;
    bus_if.flash_ready = 1'b1;
    rst_n = 1'b0;

    #1;
    chk("rst_ack0",   32'(bus_if.ack0), 32'd0);
    chk("rst_ack1",   32'(bus_if.ack1), 32'd0);
    chk("rst_busy",   32'(bus_if.busy), 32'd0);
    chk("rst_enable", 32'(bus_if.flash_enable), 32'd0);
    chk("rst_faddr",  32'(bus_if.flash_addr), 32'd0);
    chk("rst_rdata",  bus_if.rdata, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-byte fetch with stale ready left high from power-up
    lat = 1;
    push_burst(1'b0, 24'h000100, 1, 32'h000000A5);
    run_port(0, 24'h000100, 2'd0);
    @(negedge clk);
    chk("idle_after_ack", 32'(bus_if.busy), 32'd0);

    // 4-byte load on port 1
    lat = 2;
    push_burst(1'b1, 24'h000010, 4, 32'hB6B7B4B5);
    run_port(1, 24'h000010, 2'd3);
    chk("rdata_hold", bus_if.rdata, 32'hB6B7B4B5);
    repeat (2) @(negedge clk);

    // Contention: same-cycle requests, then port 0 re-requests during port 1's burst
    lat = 0;
    push_burst(1'b0, 24'h000200, 2, 32'h0000A4A5);
    push_burst(1'b1, 24'h000333, 1, 32'h00000096);
    push_burst(1'b0, 24'h000044, 3, 32'h00E3E0E1);
    fork
      begin
        run_port(0, 24'h000200, 2'd1);
        repeat (3) @(negedge clk);
        chk("p1_busy_when_p0_rerequests", 32'(bus_if.busy), 32'd1);
        run_port(0, 24'h000044, 2'd2);
      end
      run_port(1, 24'h000333, 2'd0);
    join
    repeat (2) @(negedge clk);

    // Address wrap across 0xFFFFFF
    lat = 3;
    push_burst(1'b0, 24'hFFFFFE, 4, 32'hA4A55A5B);
    run_port(0, 24'hFFFFFE, 2'd3);
    repeat (2) @(negedge clk);

    // Reset during the third byte of a 4-byte burst
    lat = 3;
    for (int i = 0; i < 4; i++) exp_addr.push_back(24'h000080 + 24'(i));
    n = accept_cnt;
    bus_if.addr0 = 24'h000080; bus_if.len0 = 2'd3; bus_if.req0 = 1'b1;
    begin
      int k;
      k = 0;
      while (accept_cnt != n + 3 && k < 2000) begin
        @(negedge clk);
        k++;
      end
      if (k >= 2000) begin
        tests++;
        fails++;
        $display("FAIL third_byte_timeout: accepts %0d expected %0d", accept_cnt - n, 3);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ack0",   32'(bus_if.ack0), 32'd0);
    chk("midrst_ack1",   32'(bus_if.ack1), 32'd0);
    chk("midrst_busy",   32'(bus_if.busy), 32'd0);
    chk("midrst_enable", 32'(bus_if.flash_enable), 32'd0);
    chk("midrst_faddr",  32'(bus_if.flash_addr), 32'd0);
    chk("midrst_rdata",  bus_if.rdata, 32'd0);
    exp_addr.delete();
    bus_if.req0 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Normal burst after reset recovery
    lat = 1;
    push_burst(1'b0, 24'h000007, 2, 32'h0000ADA2);
    run_port(0, 24'h000007, 2'd1);
    repeat (5) @(negedge clk);

    chk("ack_queue_drained",  32'(exp_port.size()), 32'd0);
    chk("addr_queue_drained", 32'(exp_addr.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
